// File: rtl/control_unit.sv
// Command/data controller: decodes validated command strobes into a saturating 12-bit DAC level
// and, in receive mode, captures upstream samples into a 128-entry circular log with AXI readback.
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ValidSignal,
  input  logic        sendEnable,
  input  logic        rec_en,
  input  logic        onSignal,
  input  logic        offSignal,
  input  logic        increaseSignal,
  input  logic        decreaseSignal,
  input  logic [7:0]  AmountSignal,
  input  logic [24:0] buf_in,
  input  logic [6:0]  read_add,
  input  logic        rd_en,
  output logic        send_enB,
  output logic        sending,
  output logic        no_order,
  output logic [11:0] outputDAC,
  output logic [24:0] read_data
);

  typedef enum logic {StOff, StActive} state_t;

  state_t      r_state, w_state_d;
  logic        r_tx_mode, r_rx_mode;
  logic [11:0] r_level, w_level_d;
  logic [11:0] w_step;
  logic [12:0] w_sum;
  logic        w_capture, w_any_cmd;
  logic [24:0] AXI_OUT;
  logic [6:0]  r_wr_ptr;
  logic [24:0] r_mem [128];

  assign w_step    = {AmountSignal, 4'h0};
  assign w_sum     = {1'b0, r_level} + {1'b0, w_step};
  assign w_capture = (r_state == StActive) && r_rx_mode;
  assign w_any_cmd = sendEnable | rec_en | onSignal | offSignal | increaseSignal | decreaseSignal;

  always_comb begin
    w_state_d = r_state;
    w_level_d = r_level;
    if (ValidSignal) begin
      if (offSignal) begin
        // Off dominates a simultaneous on and always zeroes the level.
        w_state_d = StOff;
        w_level_d = '0;
      end else begin
        if (r_state == StActive) begin
          if (increaseSignal && !decreaseSignal) begin
            w_level_d = w_sum[12] ? 12'hFFF : w_sum[11:0];
          end else if (decreaseSignal && !increaseSignal) begin
            w_level_d = (r_level < w_step) ? 12'h000 : r_level - w_step;
          end
        end
        if (onSignal) begin
          w_state_d = StActive;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StOff;
      r_tx_mode <= 1'b0;
      r_rx_mode <= 1'b0;
      r_level   <= '0;
      no_order  <= 1'b1;
      sending   <= 1'b0;
      send_enB  <= 1'b0;
      AXI_OUT   <= '0;
      r_wr_ptr  <= '0;
      read_data <= '0;
    end else begin
      r_state  <= w_state_d;
      r_level  <= w_level_d;
      no_order <= !(ValidSignal && w_any_cmd);
      if (ValidSignal) begin
        r_tx_mode <= sendEnable;
        r_rx_mode <= rec_en;
      end
      sending  <= w_capture;
      send_enB <= w_capture;
      if (w_capture) begin
        AXI_OUT  <= buf_in;
        r_wr_ptr <= r_wr_ptr + 7'd1;
      end
      if (rd_en) begin
        read_data <= r_mem[read_add];
      end
    end
  end

  // Sample log is not reset; only the write pointer is.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= buf_in;
    end
  end

  // Level is forced to zero on every entry to OFF, so it doubles as the DAC word.
  assign outputDAC = r_level;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: a behavioural model is compared against the DUT every cycle,
// plus directed sequences with hand-computed expectations.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ValidSignal, sendEnable, rec_en, onSignal, offSignal;
  logic        increaseSignal, decreaseSignal, rd_en;
  logic [7:0]  AmountSignal;
  logic [24:0] buf_in;
  logic [6:0]  read_add;
  logic        send_enB, sending, no_order;
  logic [11:0] outputDAC;
  logic [24:0] read_data;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  control_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ValidSignal   (ValidSignal),
    .sendEnable    (sendEnable),
    .rec_en        (rec_en),
    .onSignal      (onSignal),
    .offSignal     (offSignal),
    .increaseSignal(increaseSignal),
    .decreaseSignal(decreaseSignal),
    .AmountSignal  (AmountSignal),
    .buf_in        (buf_in),
    .read_add      (read_add),
    .rd_en         (rd_en),
    .send_enB      (send_enB),
    .sending       (sending),
    .no_order      (no_order),
    .outputDAC     (outputDAC),
    .read_data     (read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: "on" flag, receive flag, integer level, circular log with write index.
  bit        m_on, m_tx, m_rx, m_no, m_sending, m_enb, m_rd_known;
  int        m_level, m_wp;
  bit [24:0] m_axi, m_rd;
  bit [24:0] m_mem  [128];
  bit        m_memv [128];

  always @(posedge clk or negedge rst_n) begin
    bit cap;
    int step;
    if (!rst_n) begin
      m_on = 0; m_tx = 0; m_rx = 0; m_level = 0; m_no = 1; m_sending = 0; m_enb = 0;
      m_axi = 0; m_rd = 0; m_rd_known = 1; m_wp = 0;
    end else begin
      cap  = m_on && m_rx;
      step = int'(AmountSignal) * 16;
      if (rd_en) begin
        m_rd       = m_mem[read_add];
        m_rd_known = m_memv[read_add];
      end
      if (cap) begin
        m_axi          = buf_in;
        m_mem[m_wp]    = buf_in;
        m_memv[m_wp]   = 1;
        m_wp           = (m_wp + 1) % 128;
      end
      m_sending = cap;
      m_enb     = cap;
      m_no      = !(ValidSignal && (sendEnable || rec_en || onSignal || offSignal ||
                                    increaseSignal || decreaseSignal));
      if (ValidSignal) begin
        if (offSignal) begin
          m_on    = 0;
          m_level = 0;
        end else begin
          if (m_on && increaseSignal && !decreaseSignal)
            m_level = (m_level + step > 4095) ? 4095 : m_level + step;
          else if (m_on && decreaseSignal && !increaseSignal)
            m_level = (m_level - step < 0) ? 0 : m_level - step;
          if (onSignal) m_on = 1;
        end
        m_tx = sendEnable;
        m_rx = rec_en;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m.no_order", {31'b0, no_order}, {31'b0, m_no});
      chk("m.sending", {31'b0, sending}, {31'b0, m_sending});
      chk("m.send_enB", {31'b0, send_enB}, {31'b0, m_enb});
      chk("m.outputDAC", {20'b0, outputDAC}, m_level);
      chk("m.AXI_OUT", {7'b0, dut.AXI_OUT}, {7'b0, m_axi});
      if (m_rd_known) chk("m.read_data", {7'b0, read_data}, {7'b0, m_rd});
    end
  end

  task automatic clr_inputs();
    ValidSignal = 0; sendEnable = 0; rec_en = 0; onSignal = 0; offSignal = 0;
    increaseSignal = 0; decreaseSignal = 0; AmountSignal = 0; buf_in = 0;
    read_add = 0; rd_en = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clr_inputs();
    rst_n = 0;
    cyc(3);
    chk("rst.no_order", {31'b0, no_order}, 32'd1);
    chk("rst.AXI_OUT", {7'b0, dut.AXI_OUT}, 32'd0);
    chk("rst.outputDAC", {20'b0, outputDAC}, 32'd0);
    chk("rst.sending", {31'b0, sending}, 32'd0);
    chk("rst.send_enB", {31'b0, send_enB}, 32'd0);
    chk("rst.read_data", {7'b0, read_data}, 32'd0);
    rst_n  = 1;
    chk_on = 1;

    // Inputs without ValidSignal are ignored.
    rec_en = 1; buf_in = 25'h0FFFFFF; onSignal = 1;
    cyc(10);
    chk("novalid.AXI_OUT", {7'b0, dut.AXI_OUT}, 32'd0);
    chk("novalid.sending", {31'b0, sending}, 32'd0);
    onSignal = 0;

    // Off with send/receive requests keeps the unit off.
    ValidSignal = 1; sendEnable = 1; rec_en = 1; offSignal = 1;
    cyc(1);
    chk("off.outputDAC", {20'b0, outputDAC}, 32'd0);
    chk("off.no_order", {31'b0, no_order}, 32'd0);
    offSignal = 0; sendEnable = 0; increaseSignal = 1; AmountSignal = 8'h10;
    cyc(2);
    chk("off.stay_sending", {31'b0, sending}, 32'd0);
    chk("off.stay_dac", {20'b0, outputDAC}, 32'd0);
    increaseSignal = 0; AmountSignal = 0;

    // On + receive: first sample two cycles later.
    onSignal = 1; buf_in = 25'h1FFFFFF;
    cyc(1);
    onSignal = 0;
    cyc(1);
    chk("rx.sending", {31'b0, sending}, 32'd1);
    chk("rx.send_enB", {31'b0, send_enB}, 32'd1);
    chk("rx.AXI_OUT", {7'b0, dut.AXI_OUT}, 32'h1FFFFFF);
    increaseSignal = 1; AmountSignal = 8'h01;
    cyc(1);
    chk("inc.0x010", {20'b0, outputDAC}, 32'h010);
    increaseSignal = 0; decreaseSignal = 1;
    cyc(1);
    chk("dec.0x000", {20'b0, outputDAC}, 32'h000);
    cyc(1);
    chk("dec.floor", {20'b0, outputDAC}, 32'h000);
    decreaseSignal = 0; increaseSignal = 1; AmountSignal = 8'hFF;
    cyc(1);
    chk("inc.0xFF0", {20'b0, outputDAC}, 32'hFF0);
    cyc(19);
    chk("inc.ceiling", {20'b0, outputDAC}, 32'hFFF);
    increaseSignal = 0; decreaseSignal = 1; AmountSignal = 8'h40;
    cyc(1);
    chk("dec.0xBFF", {20'b0, outputDAC}, 32'hBFF);
    decreaseSignal = 0; offSignal = 1;
    cyc(1);
    chk("off.clears_dac", {20'b0, outputDAC}, 32'h000);
    clr_inputs();

    // Wrap-around: 130 samples of value = index from a fresh write pointer.
    @(posedge clk); #2 rst_n = 0;
    #1 chk("arst.sending", {31'b0, sending}, 32'd0);
    cyc(1);
    rst_n = 1;
    ValidSignal = 1; onSignal = 1; rec_en = 1;
    cyc(1);
    ValidSignal = 0; onSignal = 0;
    for (int i = 0; i < 130; i++) begin
      buf_in = 25'(i);
      cyc(1);
    end
    rd_en = 1; read_add = 7'd1;
    cyc(1);
    chk("wrap.addr1", {7'b0, read_data}, 32'd129);
    read_add = 7'd0;
    cyc(1);
    chk("wrap.addr0", {7'b0, read_data}, 32'd128);
    read_add = 7'd5;
    cyc(1);
    chk("wrap.addr5", {7'b0, read_data}, 32'd5);
    rd_en = 0; read_add = 7'd9;
    cyc(1);
    chk("read.hold", {7'b0, read_data}, 32'd5);

    // Randomized traffic with occasional asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      ValidSignal    = ($urandom_range(0, 9) < 8);
      sendEnable     = $urandom_range(0, 1);
      rec_en         = ($urandom_range(0, 3) != 0);
      onSignal       = ($urandom_range(0, 4) == 0);
      offSignal      = ($urandom_range(0, 19) == 0);
      increaseSignal = $urandom_range(0, 1);
      decreaseSignal = $urandom_range(0, 1);
      AmountSignal   = 8'($urandom);
      buf_in         = 25'($urandom);
      read_add       = 7'($urandom);
      rd_en          = $urandom_range(0, 1);
      if (n % 8 == 3) begin
        ValidSignal = 0;
        rec_en = 0; sendEnable = 0; onSignal = 0; offSignal = 0;
        increaseSignal = 0; decreaseSignal = 0;
      end
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk); #2 rst_n = 0;
        #1 chk("rand.arst_sending", {31'b0, sending}, 32'd0);
        cyc(1);
        rst_n = 1;
      end else begin
        cyc(1);
      end
    end

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
